dac_sample_sequencer: RTL and testbench

//  AXI4-Lite write master that plays a sample table into the DAC interface slave at a programmed rate.

---
 rtl/dac_sample_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_dac_sample_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_sequencer.sv
// AXI4-Lite write master that replays a small sample table into a DAC slave,
// one single-beat write per rate tick, with sticky DONE/UNDERRUN status.
module dac_sample_sequencer #(
  parameter int          DEPTH    = 16,
  parameter int          AW       = 4,
  parameter int          DIVW     = 16,
  parameter logic [31:0] DAC_ADDR = 32'hFFFFFFF1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic            LOOP,
  input  logic [DIVW-1:0] DIV,
  input  logic [AW-1:0]   LAST_IDX,
  input  logic            TBL_WE,
  input  logic [AW-1:0]   TBL_ADDR,
  input  logic [11:0]     TBL_DATA,
  output logic            AWVALID,
  input  logic            AWREADY,
  output logic [31:0]     AWADDR,
  output logic            WVALID,
  input  logic            WREADY,
  output logic [31:0]     WDATA,
  output logic [3:0]      WSTRB,
  input  logic            BVALID,
  output logic            BREADY,
  output logic            BUSY,
  output logic            DONE,
  output logic            UNDERRUN
);

  typedef enum logic [1:0] {IDLE, WAIT_TICK, SEND, RESP} state_t;

  state_t          state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   last_q, last_d;
  logic            loop_q, loop_d;
  logic            en_prev_q;
  logic            abort_q, abort_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            done_q, done_d;
  logic            underrun_q, underrun_d;
  logic [31:0]     awaddr_q, awaddr_d;
  logic [11:0]     sample_q, sample_d;
  logic [3:0]      wstrb_q, wstrb_d;

  logic            active;
  logic            tick;
  logic            aw_ok;
  logic            w_ok;

  logic [11:0]     mem [DEPTH];

  // Table is deliberately not reset; a same-edge write and fetch sees the old word.
  always_ff @(posedge CLK) begin
    if (TBL_WE) begin
      mem[TBL_ADDR] <= TBL_DATA;
    end
  end

  always_comb begin
    active = EN && (state_q != IDLE);
    tick   = active && (cnt_q == DIV);
    cnt_d  = (!active || tick) ? '0 : cnt_q + 1'b1;
    aw_ok  = !awvalid_q || AWREADY;
    w_ok   = !wvalid_q || WREADY;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    loop_d     = loop_q;
    abort_d    = abort_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    done_d     = done_q;
    underrun_d = underrun_q;
    awaddr_d   = awaddr_q;
    sample_d   = sample_q;
    wstrb_d    = wstrb_q;

    case (state_q)
      IDLE: begin
        if (EN && !en_prev_q) begin
          idx_d      = '0;
          last_d     = LAST_IDX;
          loop_d     = LOOP;
          done_d     = 1'b0;
          underrun_d = 1'b0;
          abort_d    = 1'b0;
          state_d    = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (!EN) begin
          state_d = IDLE;
        end else if (tick) begin
          awaddr_d  = DAC_ADDR;
          sample_d  = mem[idx_q];
          wstrb_d   = 4'hF;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (tick) underrun_d = 1'b1;
        if (!EN) abort_d = 1'b1;
        if (awvalid_q && AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && WREADY) wvalid_d = 1'b0;
        if (aw_ok && w_ok) begin
          bready_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (tick) underrun_d = 1'b1;
        if (!EN) abort_d = 1'b1;
        if (BVALID && bready_q) begin
          bready_d = 1'b0;
          // A run stopped by EN never reports DONE, even on its last sample.
          if (abort_q || !EN) begin
            state_d = IDLE;
          end else if (idx_q == last_q) begin
            if (loop_q) begin
              idx_d   = '0;
              state_d = WAIT_TICK;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = WAIT_TICK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      loop_q     <= 1'b0;
      en_prev_q  <= 1'b0;
      abort_q    <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      awaddr_q   <= '0;
      sample_q   <= '0;
      wstrb_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      loop_q     <= loop_d;
      en_prev_q  <= EN;
      abort_q    <= abort_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      awaddr_q   <= awaddr_d;
      sample_q   <= sample_d;
      wstrb_q    <= wstrb_d;
    end
  end

  assign AWVALID  = awvalid_q;
  assign AWADDR   = awaddr_q;
  assign WVALID   = wvalid_q;
  assign WDATA    = {20'b0, sample_q};
  assign WSTRB    = wstrb_q;
  assign BREADY   = bready_q;
  assign BUSY     = (state_q != IDLE);
  assign DONE     = done_q;
  assign UNDERRUN = underrun_q;

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Directed bench for dac_sample_sequencer: a delay-programmable AXI4-Lite slave
// logs every write; directed scenarios compare against hand-computed values.
module tb_dac_sample_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, loop_en, tbl_we;
  logic [15:0] div;
  logic [3:0]  last_idx, tbl_addr;
  logic [11:0] tbl_data;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic        busy, done, underrun;

  int n_checks = 0;
  int n_fail   = 0;

  // slave model state
  int          aw_dly = 0, w_dly = 0, b_dly = 0;
  int          aw_wait, w_wait, b_wait, b_cnt, cyc;
  bit          aw_got, w_got, b_pend, aw_prev;
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  logic [3:0]  strb_log[$];
  int          rise_log[$];

  always #5 clk = ~clk;

  dac_sample_sequencer dut (
    .CLK(clk), .RST(rst_n), .EN(en), .LOOP(loop_en), .DIV(div), .LAST_IDX(last_idx),
    .TBL_WE(tbl_we), .TBL_ADDR(tbl_addr), .TBL_DATA(tbl_data),
    .AWVALID(awvalid), .AWREADY(awready), .AWADDR(awaddr),
    .WVALID(wvalid), .WREADY(wready), .WDATA(wdata), .WSTRB(wstrb),
    .BVALID(bvalid), .BREADY(bready),
    .BUSY(busy), .DONE(done), .UNDERRUN(underrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic tbl_write(input logic [3:0] a, input logic [11:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_data = d;
    step();
    tbl_we = 1'b0;
  endtask

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); strb_log.delete(); rise_log.delete();
    b_cnt = 0;
  endtask

  task automatic start_run();
    en = 1'b0;
    step();
    en = 1'b1;
    step();
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy) break;
      step();
    end
    check_eq(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_awvalid(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc; i++) begin
      if (awvalid) break;
      step();
    end
    check_eq(tag, {31'b0, awvalid}, 32'd1);
  endtask

  // AXI4-Lite slave: decides READY/VALID at each falling edge, logs handshakes
  // that will complete on the next rising edge.
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    aw_wait = 0; w_wait = 0; b_wait = 0; b_cnt = 0; cyc = 0;
    aw_got = 0; w_got = 0; b_pend = 0; aw_prev = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        aw_wait = 0; w_wait = 0; b_wait = 0;
        aw_got = 0; w_got = 0; b_pend = 0; aw_prev = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      end else begin
        if (b_pend) begin
          b_wait++;
          bvalid = (b_wait > b_dly);
          if (bvalid && bready) begin
            b_pend = 0; b_wait = 0; b_cnt++;
          end
        end else begin
          bvalid = 1'b0;
        end
        if (awvalid && !aw_prev) rise_log.push_back(cyc);
        aw_prev = awvalid;
        if (awvalid) begin
          aw_wait++;
          awready = (aw_wait > aw_dly);
          if (awready) begin
            aw_log.push_back(awaddr); aw_wait = 0; aw_got = 1;
          end
        end else begin
          awready = 1'b0;
        end
        if (wvalid) begin
          w_wait++;
          wready = (w_wait > w_dly);
          if (wready) begin
            w_log.push_back(wdata); strb_log.push_back(wstrb); w_wait = 0; w_got = 1;
          end
        end else begin
          wready = 1'b0;
        end
        if (aw_got && w_got) begin
          b_pend = 1; aw_got = 0; w_got = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; loop_en = 1'b0; div = 16'd3; last_idx = 4'd2;
    tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    #2 rst_n = 1'b0;
    step();
    check_eq("rst_awvalid", {31'b0, awvalid}, 32'd0);
    check_eq("rst_awaddr",  awaddr, 32'd0);
    check_eq("rst_wdata",   wdata,  32'd0);
    check_eq("rst_wstrb",   {28'b0, wstrb}, 32'd0);
    check_eq("rst_flags",   {26'b0, wvalid, bready, busy, done, underrun, 1'b0}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    tbl_write(4'd0, 12'h111);
    tbl_write(4'd1, 12'h222);
    tbl_write(4'd2, 12'h333);

    // 1: one-shot run of three samples, slave always ready
    clear_logs(); aw_dly = 0; w_dly = 0; b_dly = 0;
    div = 16'd3; last_idx = 4'd2; loop_en = 1'b0;
    start_run();
    wait_idle(100, "t1_idle");
    check_eq("t1_count",   w_log.size(), 32'd3);
    check_eq("t1_wdata0",  w_log[0], 32'h111);
    check_eq("t1_wdata1",  w_log[1], 32'h222);
    check_eq("t1_wdata2",  w_log[2], 32'h333);
    check_eq("t1_awaddr0", aw_log[0], 32'hFFFFFFF1);
    check_eq("t1_awaddr2", aw_log[2], 32'hFFFFFFF1);
    check_eq("t1_wstrb",   {28'b0, strb_log[1]}, 32'hF);
    check_eq("t1_gap01",   rise_log[1] - rise_log[0], 32'd4);
    check_eq("t1_gap12",   rise_log[2] - rise_log[1], 32'd4);
    check_eq("t1_done",    {31'b0, done}, 32'd1);
    check_eq("t1_underrun", {31'b0, underrun}, 32'd0);

    // 2: AWREADY late by 3 cycles, WREADY immediate, single sample
    clear_logs(); aw_dly = 3; div = 16'd7; last_idx = 4'd0;
    start_run();
    check_eq("t2_done_cleared", {31'b0, done}, 32'd0);
    wait_awvalid(50, "t2_awvalid_seen");
    check_eq("t2_v1_wvalid", {31'b0, wvalid}, 32'd1);
    check_eq("t2_v1_bready", {31'b0, bready}, 32'd0);
    for (int i = 2; i <= 4; i++) begin
      step();
      check_eq($sformatf("t2_v%0d_wvalid", i),  {31'b0, wvalid}, 32'd0);
      check_eq($sformatf("t2_v%0d_awvalid", i), {31'b0, awvalid}, 32'd1);
      check_eq($sformatf("t2_v%0d_awaddr", i),  awaddr, 32'hFFFFFFF1);
      check_eq($sformatf("t2_v%0d_bready", i),  {31'b0, bready}, 32'd0);
    end
    step();
    check_eq("t2_v5_awvalid", {31'b0, awvalid}, 32'd0);
    check_eq("t2_v5_bready",  {31'b0, bready}, 32'd1);
    wait_idle(50, "t2_idle");
    check_eq("t2_wdata0", w_log[0], 32'h111);
    check_eq("t2_done",   {31'b0, done}, 32'd1);

    // 3: tick every cycle with slow B -> underrun, but no skipped samples
    clear_logs(); aw_dly = 0; b_dly = 5; div = 16'd0; last_idx = 4'd2;
    start_run();
    wait_idle(200, "t3_idle");
    check_eq("t3_underrun", {31'b0, underrun}, 32'd1);
    check_eq("t3_count",    w_log.size(), 32'd3);
    check_eq("t3_wdata0",   w_log[0], 32'h111);
    check_eq("t3_wdata1",   w_log[1], 32'h222);
    check_eq("t3_wdata2",   w_log[2], 32'h333);
    check_eq("t3_done",     {31'b0, done}, 32'd1);

    // 4: looping over two entries, EN dropped while waiting for B
    clear_logs(); b_dly = 2; div = 16'd5; last_idx = 4'd1; loop_en = 1'b1;
    start_run();
    for (int i = 0; i < 300; i++) begin
      if (w_log.size() >= 4) break;
      step();
    end
    for (int i = 0; i < 20; i++) begin
      if (bready) break;
      step();
    end
    check_eq("t4_in_resp", {31'b0, bready}, 32'd1);
    en = 1'b0;
    wait_idle(50, "t4_idle");
    check_eq("t4_count",   w_log.size(), 32'd4);
    check_eq("t4_bcount",  b_cnt, 32'd4);
    check_eq("t4_wdata2",  w_log[2], 32'h111);
    check_eq("t4_wdata3",  w_log[3], 32'h222);
    check_eq("t4_done",    {31'b0, done}, 32'd0);
    check_eq("t4_bready",  {31'b0, bready}, 32'd0);
    check_eq("t4_underrun", {31'b0, underrun}, 32'd0);

    // 5: asynchronous reset while AWVALID is pending
    clear_logs(); aw_dly = 20; b_dly = 0; div = 16'd3; last_idx = 4'd2; loop_en = 1'b0;
    start_run();
    wait_awvalid(50, "t5_awvalid_seen");
    rst_n = 1'b0;
    #1;
    check_eq("t5_awvalid", {31'b0, awvalid}, 32'd0);
    check_eq("t5_awaddr",  awaddr, 32'd0);
    check_eq("t5_wdata",   wdata, 32'd0);
    check_eq("t5_wstrb",   {28'b0, wstrb}, 32'd0);
    check_eq("t5_flags",   {27'b0, wvalid, bready, busy, done, underrun}, 32'd0);
    step();
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    clear_logs(); aw_dly = 0;
    start_run();
    wait_idle(100, "t5_idle");
    check_eq("t5_count",  w_log.size(), 32'd3);
    check_eq("t5_wdata0", w_log[0], 32'h111);
    check_eq("t5_done",   {31'b0, done}, 32'd1);

    // 6: rewrite entry 1 mid-run, before its tick
    clear_logs(); div = 16'd7; last_idx = 4'd2;
    start_run();
    for (int i = 0; i < 50; i++) begin
      if (w_log.size() >= 1) break;
      step();
    end
    tbl_write(4'd1, 12'hABC);
    wait_idle(100, "t6_idle");
    check_eq("t6_wdata0", w_log[0], 32'h111);
    check_eq("t6_wdata1", w_log[1], 32'h00000ABC);
    check_eq("t6_wdata2", w_log[2], 32'h333);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
